// File: rtl/bp_pkg.sv
// Shared types and width helpers for the gshare branch predictor.
package bp_pkg;

  typedef enum logic {
    BP_INIT = 1'b0,
    BP_RUN  = 1'b1
  } bp_state_t;

  function automatic int bp_clog2(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int bp_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Weakly-not-taken reset value; collapses to 0 for 1-bit counters.
  function automatic int bp_wnt(input int ctr_w);
    return (1 << (ctr_w - 1)) - 1;
  endfunction

endpackage

// File: rtl/bp_btb.sv
// Direct-mapped tagged branch target buffer: combinational lookup, registered write.
module bp_btb
  import bp_pkg::*;
#(
  parameter int BTB_ENTRIES = 16,
  localparam int BIDX_W = bp_clog2(BTB_ENTRIES),
  localparam int TAG_W  = 30 - BIDX_W
) (
  input  logic              clk,
  input  logic [31:0]       lookup_pc,
  output logic              hit,
  output logic [31:0]       target,
  input  logic              wr_en,
  input  logic [31:0]       wr_pc,
  input  logic [31:0]       wr_target,
  input  logic              clr_en,
  input  logic [BIDX_W-1:0] clr_idx
);

  logic [BTB_ENTRIES-1:0] valid;
  logic [TAG_W-1:0]       tag_mem [BTB_ENTRIES];
  logic [31:0]            tgt_mem [BTB_ENTRIES];

  logic [BIDX_W-1:0] rd_idx;
  logic [BIDX_W-1:0] wr_idx;
  logic [3:0]        unused_bits;

  assign rd_idx      = lookup_pc[BIDX_W+1:2];
  assign wr_idx      = wr_pc[BIDX_W+1:2];
  assign unused_bits = {lookup_pc[1:0], wr_pc[1:0]};

  assign hit    = valid[rd_idx] && (tag_mem[rd_idx] == lookup_pc[31:BIDX_W+2]);
  assign target = hit ? tgt_mem[rd_idx] : 32'd0;

  // The clear sweep owns the array; tag/target contents are don't-care while invalid.
  always_ff @(posedge clk) begin
    if (clr_en) begin
      valid[clr_idx] <= 1'b0;
    end else if (wr_en) begin
      valid[wr_idx]   <= 1'b1;
      tag_mem[wr_idx] <= wr_pc[31:BIDX_W+2];
      tgt_mem[wr_idx] <= wr_target;
    end
  end

endmodule

// File: rtl/branch_predictor_gshare.sv
// Gshare/bimodal direction predictor with BTB, init sweep and perf counters.
// state   | meaning
// BP_INIT | sweeping tables to reset values, outputs forced quiet, updates ignored
// BP_RUN  | predicting and accepting updates
module branch_predictor_gshare
  import bp_pkg::*;
#(
  parameter int BHT_ENTRIES = 64,
  parameter int CTR_W       = 2,
  parameter int GHR_W       = 6,
  parameter int USE_GSHARE  = 1,
  parameter int BTB_ENTRIES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  output logic        predict_taken,
  output logic        btb_hit,
  output logic [31:0] predict_target,
  input  logic        update_en,
  input  logic [31:0] pc_u,
  input  logic        branch_taken,
  input  logic [31:0] target_u,
  input  logic        predicted_taken_u,
  output logic        ready,
  output logic [31:0] update_count,
  output logic [31:0] mispredict_count
);

  localparam int IDX_W  = bp_clog2(BHT_ENTRIES);
  localparam int BIDX_W = bp_clog2(BTB_ENTRIES);
  localparam int SWEEP  = bp_max(BHT_ENTRIES, BTB_ENTRIES);
  localparam int PTR_W  = bp_clog2(SWEEP);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(SWEEP - 1);
  localparam logic [CTR_W-1:0] CTR_WNT  = CTR_W'(bp_wnt(CTR_W));
  localparam logic [CTR_W-1:0] CTR_MAX  = '1;

  bp_state_t         state;
  logic [PTR_W-1:0]  init_ptr;
  logic [GHR_W-1:0]  ghr;
  logic [CTR_W-1:0]  bht [BHT_ENTRIES];

  logic              run;
  logic              accept;
  logic [IDX_W-1:0]  hist;
  logic [IDX_W-1:0]  rd_idx;
  logic [IDX_W-1:0]  up_idx;
  logic [CTR_W-1:0]  ctr_cur;
  logic [CTR_W-1:0]  ctr_nxt;
  logic [GHR_W:0]    ghr_shift;
  logic              btb_hit_raw;
  logic [31:0]       btb_target_raw;
  logic [3:0]        unused_bits;

  assign run         = (state == BP_RUN);
  assign accept      = run && update_en && !reset;
  assign unused_bits = {pc[1:0], pc_u[1:0]};

  // Updates are non-speculative, so one history serves both read and training.
  assign hist   = (USE_GSHARE != 0) ? IDX_W'(ghr) : '0;
  assign rd_idx = pc[IDX_W+1:2] ^ hist;
  assign up_idx = pc_u[IDX_W+1:2] ^ hist;

  assign ctr_cur = bht[up_idx];
  always_comb begin
    ctr_nxt = ctr_cur;
    if (branch_taken) begin
      if (ctr_cur != CTR_MAX) ctr_nxt = ctr_cur + 1'b1;
    end else begin
      if (ctr_cur != '0) ctr_nxt = ctr_cur - 1'b1;
    end
  end

  assign ghr_shift = {ghr, branch_taken};

  always_ff @(posedge clk) begin
    if (state == BP_INIT) begin
      bht[init_ptr[IDX_W-1:0]] <= CTR_WNT;
    end else if (accept) begin
      bht[up_idx] <= ctr_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= BP_INIT;
      init_ptr         <= '0;
      ghr              <= '0;
      update_count     <= '0;
      mispredict_count <= '0;
    end else begin
      case (state)
        BP_INIT: begin
          ghr <= '0;
          if (init_ptr == LAST_PTR) state <= BP_RUN;
          else init_ptr <= init_ptr + 1'b1;
        end
        BP_RUN: begin
          if (update_en) begin
            ghr <= ghr_shift[GHR_W-1:0];
            if (update_count != 32'hFFFF_FFFF) update_count <= update_count + 32'd1;
            if ((branch_taken != predicted_taken_u) && (mispredict_count != 32'hFFFF_FFFF))
              mispredict_count <= mispredict_count + 32'd1;
          end
        end
        default: state <= BP_INIT;
      endcase
    end
  end

  bp_btb #(
    .BTB_ENTRIES(BTB_ENTRIES)
  ) u_btb (
    .clk       (clk),
    .lookup_pc (pc),
    .hit       (btb_hit_raw),
    .target    (btb_target_raw),
    .wr_en     (accept && branch_taken),
    .wr_pc     (pc_u),
    .wr_target (target_u),
    .clr_en    (state == BP_INIT),
    .clr_idx   (init_ptr[BIDX_W-1:0])
  );

  assign ready          = run;
  assign predict_taken  = run && bht[rd_idx][CTR_W-1];
  assign btb_hit        = run && btb_hit_raw;
  assign predict_target = btb_hit ? btb_target_raw : 32'd0;

endmodule
